ahbl_arbiter_2m: RTL

- Two-master AHB-Lite bus arbiter that shares the single system AHB-Lite bus between the Hazard2 CPU (M0) and a second bus master (M1, e.g. the planned DMA/accelerator engine).
- Sits between the masters and the ahbl_splitter_4 slave fabric.
- Each master sees a private AHB-Lite port. The arbiter stalls a losing master via its HREADY, muxes address/control by address-phase grant and HWDATA by data-phase owner, and never breaks a transfer mid-phase.

---
 rtl/ahbl_pkg.sv | 23 ++
 rtl/ahbl_arb_core.sv | 71 +++++++
 rtl/ahbl_arbiter_2m.sv | 85 ++++++++
 3 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the system bus fabric.
// Transfer encodings and arbitration policy selectors.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic logic is_req(input logic [1:0] t);
    return t[1];
  endfunction

  function automatic logic is_seq(input logic [1:0] t);
    return t == HTRANS_SEQ;
  endfunction

endpackage

// File: rtl/ahbl_arb_core.sv
// Two-master grant engine: request arbitration, burst/stall
// locking and the address/data-phase ownership registers.
module ahbl_arb_core
  import ahbl_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] seq,
  input  logic       s_hready,
  output logic       grant,
  output logic       downer,
  output logic       dvalid
);

  logic grant_q;
  logic hold_q;
  logic last_q;
  logic downer_q;
  logic dvalid_q;

  logic arb_g;
  logic lock;
  logic req_g;

  always_comb begin
    arb_g = grant_q;
    if (ARB_MODE == ARB_FIXED) begin
      if (req[0])      arb_g = 1'b0;
      else if (req[1]) arb_g = 1'b1;
    end else begin
      case (req)
        2'b11:   arb_g = ~last_q;
        2'b01:   arb_g = 1'b0;
        2'b10:   arb_g = 1'b1;
        default: arb_g = grant_q;
      endcase
    end
  end

  // A SEQ beat from the current owner keeps the burst intact.
  assign lock  = hold_q | seq[grant_q];
  assign grant = lock ? grant_q : arb_g;
  assign req_g = req[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= 1'b0;
      hold_q   <= 1'b0;
      last_q   <= 1'b1;
      downer_q <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      grant_q <= grant;
      hold_q  <= req_g & ~s_hready;
      if (s_hready) begin
        dvalid_q <= req_g;
        if (req_g) begin
          downer_q <= grant;
          last_q   <= grant;
        end
      end
    end
  end

  assign downer = downer_q;
  assign dvalid = dvalid_q;

endmodule

// File: rtl/ahbl_arbiter_2m.sv
// Two-master AHB-Lite arbiter in front of the slave splitter.
// Muxes address by grant, write data by data-phase owner.
module ahbl_arbiter_2m
  import ahbl_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic [2:0]    M0_HSIZE,
  input  logic          M0_HWRITE,
  input  logic [DW-1:0] M0_HWDATA,
  output logic          M0_HREADY,
  output logic [DW-1:0] M0_HRDATA,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic [2:0]    M1_HSIZE,
  input  logic          M1_HWRITE,
  input  logic [DW-1:0] M1_HWDATA,
  output logic          M1_HREADY,
  output logic [DW-1:0] M1_HRDATA,
  output logic [AW-1:0] S_HADDR,
  output logic [1:0]    S_HTRANS,
  output logic [2:0]    S_HSIZE,
  output logic          S_HWRITE,
  output logic [DW-1:0] S_HWDATA,
  input  logic          S_HREADY,
  input  logic [DW-1:0] S_HRDATA,
  output logic          HMASTER
);

  logic [1:0] req;
  logic [1:0] seq;
  logic       grant;
  logic       downer;
  logic       dvalid;

  assign req = {is_req(M1_HTRANS), is_req(M0_HTRANS)};
  assign seq = {is_seq(M1_HTRANS), is_seq(M0_HTRANS)};

  ahbl_arb_core #(
    .ARB_MODE(ARB_MODE)
  ) u_core (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .req     (req),
    .seq     (seq),
    .s_hready(S_HREADY),
    .grant   (grant),
    .downer  (downer),
    .dvalid  (dvalid)
  );

  assign S_HADDR  = grant ? M1_HADDR  : M0_HADDR;
  assign S_HTRANS = grant ? M1_HTRANS : M0_HTRANS;
  assign S_HSIZE  = grant ? M1_HSIZE  : M0_HSIZE;
  assign S_HWRITE = grant ? M1_HWRITE : M0_HWRITE;
  assign S_HWDATA = downer ? M1_HWDATA : M0_HWDATA;
  assign HMASTER  = downer;

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

  // Owners follow the slave; losers stall; idle masters see ready.
  always_comb begin
    M0_HREADY = 1'b1;
    if ((dvalid && !downer) || !grant)
      M0_HREADY = S_HREADY;
    else if (req[0])
      M0_HREADY = 1'b0;
  end

  always_comb begin
    M1_HREADY = 1'b1;
    if ((dvalid && downer) || grant)
      M1_HREADY = S_HREADY;
    else if (req[1])
      M1_HREADY = 1'b0;
  end

endmodule
